// File: rtl/spi_slave_reg_ctrl_if.sv
// Internal register bus between spi_slave_reg_ctrl (master) and the
// register file (slave).
//   bus_addr  : 7-bit register address          (master -> slave)
//   bus_wdata : write data                      (master -> slave)
//   bus_wr    : write strobe, held until ack    (master -> slave)
//   bus_rd    : read strobe, held until ack     (master -> slave)
//   bus_rdata : read data, valid with bus_ack   (slave -> master)
//   bus_ack   : transaction complete            (slave -> master)
interface spi_slave_reg_ctrl_if;
  logic [6:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       bus_wr;
  logic       bus_rd;
  logic [7:0] bus_rdata;
  logic       bus_ack;

  modport master (output bus_addr, bus_wdata, bus_wr, bus_rd,
                  input  bus_rdata, bus_ack);
  modport slave  (input  bus_addr, bus_wdata, bus_wr, bus_rd,
                  output bus_rdata, bus_ack);
endinterface

// File: rtl/spi_slave_reg_ctrl.sv
// Register-access controller behind the spi_slave word engine. The first
// word of a frame is a command {rnw, addr[6:0]}; following words are written
// to (or prefetched from) the register bus with address auto-increment.
//   clk, rst            : clock, async active-high reset
//   en                  : block enable; low forces IDLE (err is kept)
//   spi_rdy/rx_data/first_byte/last_byte : word and frame-end from spi_slave
//   spi_rdy_ack, spi_last_byte_ack       : one-cycle acknowledge pulses
//   spi_tx_data         : next word spi_slave shifts out
//   bus                 : register bus master port
//   busy                : FSM not in IDLE
//   err, err_clr        : sticky bus-timeout flag and its clear pulse
module spi_slave_reg_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        spi_rdy,
  input  logic [7:0]                  spi_rx_data,
  input  logic                        spi_first_byte,
  input  logic                        spi_last_byte,
  output logic                        spi_rdy_ack,
  output logic                        spi_last_byte_ack,
  output logic [7:0]                  spi_tx_data,
  spi_slave_reg_ctrl_if.master        bus,
  output logic                        busy,
  output logic                        err,
  input  logic                        err_clr
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACK    = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_WR_BUS = 3'd3;
  localparam logic [2:0] S_RD_BUS = 3'd4;
  localparam logic [2:0] S_LOAD   = 3'd5;
  localparam logic [2:0] S_STREAM = 3'd6;
  localparam logic [2:0] S_END    = 3'd7;

  // What the word latched at the rdy handshake should turn into.
  localparam logic [1:0] K_CMD  = 2'd0;
  localparam logic [1:0] K_DATA = 2'd1;
  localparam logic [1:0] K_DROP = 2'd2;

  localparam int            CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  typedef struct packed {
    logic [2:0]    state;
    logic [6:0]    addr;
    logic [7:0]    wdata;
    logic          wr;
    logic          rd;
    logic          rdy_ack;
    logic          lb_ack;
    logic [7:0]    tx;
    logic [7:0]    rx;
    logic [1:0]    kind;
    logic          rnw;
    logic [7:0]    rd_q;
    logic [CW-1:0] cnt;
    logic          last_pend;
    logic [1:0]    lb_hold;
  } ctrl_t;

  function automatic ctrl_t ctrl_rst();
    ctrl_t r;
    r    = '0;
    r.tx = 8'hFF;
    return r;
  endfunction

  ctrl_t c, n;
  logic  last_seen, tmo, bus_done, tmo_evt;

  // spi_slave keeps last_byte high until acked, so it is remembered while a
  // bus transaction finishes; lb_hold masks it right after our own ack.
  assign last_seen = c.last_pend | (spi_last_byte & (c.lb_hold == 2'd0));
  assign tmo       = (c.cnt == TMO_LAST);
  assign bus_done  = bus.bus_ack | tmo;
  assign tmo_evt   = (c.state == S_WR_BUS || c.state == S_RD_BUS) &&
                     !bus.bus_ack && tmo;

  always_comb begin
    n         = c;
    n.rdy_ack = 1'b0;
    n.lb_ack  = 1'b0;
    if (c.lb_hold != 2'd0) n.lb_hold = c.lb_hold - 2'd1;
    else if (spi_last_byte) n.last_pend = 1'b1;

    case (c.state)
      S_IDLE, S_STREAM: begin
        // A pending word beats frame end: it belongs to the current frame.
        if (spi_rdy) begin
          n.rdy_ack = 1'b1;
          n.rx      = spi_rx_data;
          if (spi_first_byte)        n.kind = K_CMD;
          else if (c.state == S_STREAM) n.kind = K_DATA;
          else                       n.kind = K_DROP;
          n.state = S_ACK;
        end else if (last_seen) begin
          n.state = S_END;
        end
      end
      // ACK and DECODE double as the two-cycle rdy holdoff.
      S_ACK: n.state = S_DECODE;
      S_DECODE: begin
        n.cnt = '0;
        case (c.kind)
          K_CMD: begin
            n.rnw   = c.rx[7];
            n.addr  = c.rx[6:0];
            n.rd    = c.rx[7];
            n.state = c.rx[7] ? S_RD_BUS : S_STREAM;
          end
          K_DATA: begin
            if (c.rnw) begin
              n.rd    = 1'b1;
              n.state = S_RD_BUS;
            end else begin
              n.wr    = 1'b1;
              n.wdata = c.rx;
              n.state = S_WR_BUS;
            end
          end
          default: n.state = S_IDLE;
        endcase
      end
      S_WR_BUS: begin
        if (bus_done) begin
          n.wr    = 1'b0;
          n.addr  = c.addr + 7'd1;
          n.state = last_seen ? S_END : S_STREAM;
        end else begin
          n.cnt = c.cnt + CW'(1);
        end
      end
      S_RD_BUS: begin
        if (bus_done) begin
          n.rd    = 1'b0;
          n.rd_q  = bus.bus_ack ? bus.bus_rdata : 8'hFF;
          n.state = S_LOAD;
        end else begin
          n.cnt = c.cnt + CW'(1);
        end
      end
      S_LOAD: begin
        n.tx    = c.rd_q;
        n.addr  = c.addr + 7'd1;
        n.state = last_seen ? S_END : S_STREAM;
      end
      S_END: begin
        // Status byte lands in the next frame's command slot.
        n.lb_ack    = 1'b1;
        n.tx        = {err, 7'h00};
        n.last_pend = 1'b0;
        n.lb_hold   = 2'd2;
        n.state     = S_IDLE;
      end
      default: n.state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      c <= ctrl_rst();
    else if (!en) c <= ctrl_rst();
    else          c <= n;
  end

  // err survives en going low; a timeout wins over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 err <= 1'b0;
    else if (en && tmo_evt)  err <= 1'b1;
    else if (err_clr)        err <= 1'b0;
  end

  assign spi_rdy_ack       = c.rdy_ack;
  assign spi_last_byte_ack = c.lb_ack;
  assign spi_tx_data       = c.tx;
  assign bus.bus_addr      = c.addr;
  assign bus.bus_wdata     = c.wdata;
  assign bus.bus_wr        = c.wr;
  assign bus.bus_rd        = c.rd;
  assign busy              = (c.state != S_IDLE);
endmodule

// File: tb/tb_spi_slave_reg_ctrl.sv
// Bench for spi_slave_reg_ctrl: table of directed frames plus hand-written
// sequences for timeout, frame end during a write, en low and rst mid-frame.
module tb_spi_slave_reg_ctrl;
  logic       clk = 1'b0;
  logic       rst, en, spi_rdy, spi_first_byte, spi_last_byte, err_clr;
  logic [7:0] spi_rx_data, spi_tx_data;
  logic       spi_rdy_ack, spi_last_byte_ack, busy, err;

  spi_slave_reg_ctrl_if bus();

  spi_slave_reg_ctrl #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .en(en),
    .spi_rdy(spi_rdy), .spi_rx_data(spi_rx_data),
    .spi_first_byte(spi_first_byte), .spi_last_byte(spi_last_byte),
    .spi_rdy_ack(spi_rdy_ack), .spi_last_byte_ack(spi_last_byte_ack),
    .spi_tx_data(spi_tx_data), .bus(bus),
    .busy(busy), .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] cmd;
    int         ndata;
    logic [7:0] d [2];
    int         ack_dly;
    logic [6:0] exp_addr [3];  // bus op addresses in order
    logic [7:0] exp_val [3];   // write: wdata per op; read: tx before data word k
  } vec_t;

  vec_t       vecs [6];
  vec_t       v;
  int         n_chk, n_pass;
  logic [7:0] mem [128];
  logic [6:0] wr_a [$];
  logic [7:0] wr_d [$];
  logic [6:0] rd_a [$];
  int         ack_dly, wait_cnt, rdy_cnt, lb_cnt, rd_hi, both_cnt;
  bit         stuck;
  time        t_wr, t_lb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic chk_idle(input string tag, input logic exp_err);
    chk({tag, " rdy_ack"}, 32'(spi_rdy_ack), 0);
    chk({tag, " lb_ack"}, 32'(spi_last_byte_ack), 0);
    chk({tag, " tx"}, 32'(spi_tx_data), 32'hFF);
    chk({tag, " addr"}, 32'(bus.bus_addr), 0);
    chk({tag, " wdata"}, 32'(bus.bus_wdata), 0);
    chk({tag, " wr"}, 32'(bus.bus_wr), 0);
    chk({tag, " rd"}, 32'(bus.bus_rd), 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " err"}, 32'(err), 32'(exp_err));
  endtask

  task automatic set_vec(input int i, input logic [7:0] cmd, input int nd,
                         input logic [7:0] d0, input logic [7:0] d1, input int dly,
                         input logic [6:0] a0, input logic [6:0] a1, input logic [6:0] a2,
                         input logic [7:0] v0, input logic [7:0] v1);
    vecs[i].cmd = cmd; vecs[i].ndata = nd; vecs[i].d[0] = d0; vecs[i].d[1] = d1;
    vecs[i].ack_dly = dly;
    vecs[i].exp_addr[0] = a0; vecs[i].exp_addr[1] = a1; vecs[i].exp_addr[2] = a2;
    vecs[i].exp_val[0] = v0; vecs[i].exp_val[1] = v1; vecs[i].exp_val[2] = 8'h00;
  endtask

  // spi_slave side: present a word, hold rdy until acked, then idle `post` cycles.
  task automatic send_word(input logic [7:0] d, input logic first, input int post);
    bit got = 1'b0;
    @(negedge clk);
    spi_rx_data = d; spi_first_byte = first; spi_rdy = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (spi_rdy_ack) got = 1'b1;
    end
    spi_rdy = 1'b0;
    chk("rdy_ack_seen", 32'(got), 1);
    repeat (post) @(negedge clk);
  endtask

  task automatic end_frame();
    bit got = 1'b0;
    @(negedge clk);
    spi_last_byte = 1'b1;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (spi_last_byte_ack) got = 1'b1;
    end
    spi_last_byte = 1'b0;
    chk("lb_ack_seen", 32'(got), 1);
    repeat (4) @(negedge clk);
  endtask

  task automatic clr_logs();
    wr_a.delete(); wr_d.delete(); rd_a.delete();
    rdy_cnt = 0; lb_cnt = 0; rd_hi = 0;
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    rst = 1'b1; en = 1'b1; spi_rdy = 1'b0; spi_first_byte = 1'b0;
    spi_last_byte = 1'b0; err_clr = 1'b0; spi_rx_data = 8'h00;
    bus.bus_ack = 1'b0; bus.bus_rdata = 8'h00;
    stuck = 1'b0; ack_dly = 0; wait_cnt = 0; both_cnt = 0; t_wr = 0; t_lb = 0;
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    mem[7'h10] = 8'hAB; mem[7'h11] = 8'hCD;
    clr_logs();

    // Register-file responder and pulse monitors, all on the falling edge.
    fork
      forever begin
        @(negedge clk);
        if (spi_rdy_ack) rdy_cnt++;
        if (spi_last_byte_ack) begin lb_cnt++; t_lb = $time; end
        if (bus.bus_rd) rd_hi++;
        if (bus.bus_wr && bus.bus_rd) both_cnt++;
        if ((bus.bus_wr || bus.bus_rd) && !bus.bus_ack) begin
          if (!stuck && wait_cnt == ack_dly) begin
            bus.bus_ack   = 1'b1;
            bus.bus_rdata = mem[bus.bus_addr];
            if (bus.bus_wr) begin
              mem[bus.bus_addr] = bus.bus_wdata;
              wr_a.push_back(bus.bus_addr);
              wr_d.push_back(bus.bus_wdata);
              t_wr = $time;
            end else begin
              rd_a.push_back(bus.bus_addr);
            end
          end else begin
            bus.bus_ack = 1'b0;
            wait_cnt++;
          end
        end else begin
          bus.bus_ack = 1'b0;
          wait_cnt = 0;
        end
      end
    join_none

    //      idx cmd    nd d0     d1     dly a0     a1     a2     v0     v1
    set_vec(0, 8'h05, 2, 8'h11, 8'h22, 0, 7'h05, 7'h06, 7'h00, 8'h11, 8'h22);
    set_vec(1, 8'h90, 2, 8'h00, 8'h00, 0, 7'h10, 7'h11, 7'h12, 8'hAB, 8'hCD);
    set_vec(2, 8'h7F, 2, 8'h33, 8'h44, 0, 7'h7F, 7'h00, 7'h00, 8'h33, 8'h44);
    set_vec(3, 8'h20, 2, 8'h5A, 8'hA5, 3, 7'h20, 7'h21, 7'h00, 8'h5A, 8'hA5);
    set_vec(4, 8'hA0, 2, 8'h00, 8'h00, 2, 7'h20, 7'h21, 7'h22, 8'h5A, 8'hA5);
    set_vec(5, 8'hFF, 2, 8'h00, 8'h00, 0, 7'h7F, 7'h00, 7'h01, 8'h33, 8'h44);

    repeat (3) @(negedge clk);
    chk_idle("reset", 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      int nops;
      v = vecs[i];
      clr_logs();
      ack_dly = v.ack_dly;
      send_word(v.cmd, 1'b1, 25);
      for (int k = 0; k < v.ndata; k++) begin
        if (v.cmd[7]) chk($sformatf("v%0d tx%0d", i, k), 32'(spi_tx_data), 32'(v.exp_val[k]));
        send_word(v.d[k], 1'b0, 25);
      end
      end_frame();
      nops = v.cmd[7] ? v.ndata + 1 : v.ndata;
      chk($sformatf("v%0d op_count", i), v.cmd[7] ? rd_a.size() : wr_a.size(), nops);
      for (int j = 0; j < nops; j++) begin
        logic [31:0] act;
        if (v.cmd[7]) act = (j < rd_a.size()) ? 32'(rd_a[j]) : 32'hDEAD;
        else          act = (j < wr_a.size()) ? 32'(wr_a[j]) : 32'hDEAD;
        chk($sformatf("v%0d addr%0d", i, j), act, 32'(v.exp_addr[j]));
        if (!v.cmd[7]) begin
          act = (j < wr_d.size()) ? 32'(wr_d[j]) : 32'hDEAD;
          chk($sformatf("v%0d wdata%0d", i, j), act, 32'(v.exp_val[j]));
        end
      end
      chk($sformatf("v%0d rdy_acks", i), rdy_cnt, v.ndata + 1);
      chk($sformatf("v%0d lb_acks", i), lb_cnt, 1);
      chk($sformatf("v%0d busy", i), 32'(busy), 0);
      chk($sformatf("v%0d err", i), 32'(err), 0);
      chk($sformatf("v%0d status", i), 32'(spi_tx_data), 32'h00);
    end

    // Bus never answers: read strobe times out after 16 cycles.
    clr_logs(); ack_dly = 0; stuck = 1'b1;
    send_word(8'h80, 1'b1, 25);
    chk("tmo rd_cycles", rd_hi, 16);
    chk("tmo err", 32'(err), 1);
    chk("tmo tx", 32'(spi_tx_data), 32'hFF);
    end_frame();
    chk("tmo status", 32'(spi_tx_data), 32'h80);
    chk("tmo busy", 32'(busy), 0);
    stuck = 1'b0;

    // en low mid-write: everything resets except err.
    clr_logs(); ack_dly = 10;
    send_word(8'h40, 1'b1, 25);
    send_word(8'h12, 1'b0, 4);
    chk("en wr_inflight", 32'(bus.bus_wr), 1);
    en = 1'b0;
    @(negedge clk);
    chk_idle("en_low", 1'b1);
    en = 1'b1;
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clr", 32'(err), 0);

    // Frame end while the write waits for a slow ack.
    clr_logs(); ack_dly = 5;
    send_word(8'h30, 1'b1, 25);
    send_word(8'h99, 1'b0, 2);
    end_frame();
    chk("ss_wr count", wr_a.size(), 1);
    chk("ss_wr addr", (wr_a.size() > 0) ? 32'(wr_a[0]) : 32'hDEAD, 32'h30);
    chk("ss_wr data", (wr_d.size() > 0) ? 32'(wr_d[0]) : 32'hDEAD, 32'h99);
    chk("ss_wr order", 32'(t_wr < t_lb), 1);
    chk("ss_wr lb_acks", lb_cnt, 1);
    chk("ss_wr busy", 32'(busy), 0);

    // rst pulse during a read strobe, then a clean frame.
    clr_logs(); ack_dly = 10;
    send_word(8'h90, 1'b1, 4);
    chk("rst rd_inflight", 32'(bus.bus_rd), 1);
    rst = 1'b1;
    @(negedge clk);
    chk_idle("rst_mid", 1'b0);
    rst = 1'b0; ack_dly = 0;
    @(negedge clk);
    clr_logs();
    send_word(8'h41, 1'b1, 25);
    send_word(8'h66, 1'b0, 25);
    end_frame();
    chk("post_rst wr addr", (wr_a.size() > 0) ? 32'(wr_a[0]) : 32'hDEAD, 32'h41);
    chk("post_rst wr data", (wr_d.size() > 0) ? 32'(wr_d[0]) : 32'hDEAD, 32'h66);
    send_word(8'hC1, 1'b1, 25);
    chk("post_rst readback", 32'(spi_tx_data), 32'h66);
    end_frame();

    chk("strobe overlap", both_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
